// File: rtl/ntt_ctrl_pkg.sv
// Shared state encoding and address helpers for the in-place radix-2 NTT/INTT sequencer.
package ntt_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int lat_calc(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

  // d = 1 << d_log; returns 2*d*(k/d) + (k mod d) using shifts and masks only.
  function automatic int unsigned rd_addr_calc(input int unsigned k, input int unsigned d_log);
    int unsigned d_mask;
    d_mask = (32'd1 << d_log) - 32'd1;
    return ((k >> d_log) << (d_log + 32'd1)) | (k & d_mask);
  endfunction

  // Twiddle exponent (k mod d) * N/(2d), with N/(2d) = 1 << (logn-1-d_log).
  function automatic int unsigned tw_calc(input int unsigned k, input int unsigned d_log,
                                          input int unsigned logn);
    int unsigned d_mask;
    d_mask = (32'd1 << d_log) - 32'd1;
    return (k & d_mask) << (logn - 32'd1 - d_log);
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Write-back delay line: {addr_1, addr_2, en} shifted DEPTH cycles, cleared on reset.
module ntt_addr_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_sh [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sh[i] <= '0;
    end else begin
      r_sh[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_sh[i] <= r_sh[i-1];
    end
  end

  assign dout = r_sh[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Sequencer for one radix-2 butterfly core: walks LOGN stages of N/2 butterflies,
// issuing reads, twiddle index and core mode, and writing back LAT cycles later.
module ntt_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int width  = 16,
  parameter int N      = 8,
  parameter int LOGN   = 3,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic            core_sel,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_1,
  output logic [LOGN-1:0] rd_addr_2,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_1,
  output logic [LOGN-1:0] wr_addr_2
);

  localparam int LAT = lat_calc(RD_LAT, BF_LAT);
  localparam int SW  = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int KW  = LOGN - 1;
  localparam int DW  = $clog2(LAT + 1);
  localparam int AW  = 2 * LOGN + 1;

  if (width < 1 || N < 4 || RD_LAT < 1 || BF_LAT < 0 || (1 << LOGN) != N) begin : g_bad_params
    $error("ntt_ctrl: invalid parameter set");
  end

  logic [1:0]      r_state;
  logic [SW-1:0]   r_s;
  logic [KW-1:0]   r_k;
  logic [DW-1:0]   r_drain;
  logic            r_mode;

  logic            w_run;
  logic [31:0]     w_d_log;
  logic [LOGN-1:0] w_a1;
  logic [LOGN-1:0] w_a2;
  logic [KW-1:0]   w_tw;
  logic [AW-1:0]   w_dly_in;
  logic [AW-1:0]   w_dly_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_drain <= '0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_mode  <= mode;
            r_s     <= '0;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          if (r_k == KW'(N/2 - 1)) begin
            r_state <= ST_DRAIN;
            r_k     <= '0;
            r_drain <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        // Hold reads off until the stage's last write has landed.
        ST_DRAIN: begin
          if (r_drain == DW'(LAT - 1)) begin
            r_drain <= '0;
            if (r_s == SW'(LOGN - 1)) begin
              r_state <= ST_DONE;
            end else begin
              r_s     <= r_s + 1'b1;
              r_state <= ST_RUN;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NTT walks distance N/2 down to 1; INTT walks 1 up to N/2.
  assign w_d_log = r_mode ? 32'(r_s) : (32'(LOGN - 1) - 32'(r_s));
  assign w_a1    = LOGN'(rd_addr_calc(32'(r_k), w_d_log));
  assign w_a2    = w_a1 + LOGN'(32'd1 << w_d_log);
  assign w_tw    = KW'(tw_calc(32'(r_k), w_d_log, 32'(LOGN)));

  assign w_run     = (r_state == ST_RUN);
  assign rd_en     = w_run;
  assign rd_addr_1 = w_run ? w_a1 : '0;
  assign rd_addr_2 = w_run ? w_a2 : '0;
  assign tw_addr   = w_run ? w_tw : '0;

  assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done     = (r_state == ST_DONE);
  assign core_sel = r_mode;

  assign w_dly_in = {rd_addr_1, rd_addr_2, rd_en};

  ntt_addr_delay #(
    .DEPTH (LAT),
    .W     (AW)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (w_dly_in),
    .dout (w_dly_out)
  );

  assign wr_addr_1 = w_dly_out[AW-1 -: LOGN];
  assign wr_addr_2 = w_dly_out[LOGN -: LOGN];
  assign wr_en     = w_dly_out[0];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: N=8 with LAT=1 (u_a) and LAT=3 (u_b).
module tb_ntt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, mode_a, start_b, mode_b;
  logic       busy_a, done_a, core_sel_a, rd_en_a, wr_en_a;
  logic [2:0] rd_addr_1_a, rd_addr_2_a, wr_addr_1_a, wr_addr_2_a;
  logic [1:0] tw_addr_a;
  logic       busy_b, done_b, core_sel_b, rd_en_b, wr_en_b;
  logic [2:0] rd_addr_1_b, rd_addr_2_b, wr_addr_1_b, wr_addr_2_b;
  logic [1:0] tw_addr_b;

  ntt_ctrl #(.width(16), .N(8), .LOGN(3), .RD_LAT(1), .BF_LAT(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .core_sel(core_sel_a),
    .rd_en(rd_en_a), .rd_addr_1(rd_addr_1_a), .rd_addr_2(rd_addr_2_a), .tw_addr(tw_addr_a),
    .wr_en(wr_en_a), .wr_addr_1(wr_addr_1_a), .wr_addr_2(wr_addr_2_a)
  );

  ntt_ctrl #(.width(16), .N(8), .LOGN(3), .RD_LAT(1), .BF_LAT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .core_sel(core_sel_b),
    .rd_en(rd_en_b), .rd_addr_1(rd_addr_1_b), .rd_addr_2(rd_addr_2_b), .tw_addr(tw_addr_b),
    .wr_en(wr_en_b), .wr_addr_1(wr_addr_1_b), .wr_addr_2(wr_addr_2_b)
  );

  int checks   = 0;
  int failures = 0;

  // Hand-computed read schedules: stage-major, four butterflies per stage.
  int ntt_a1  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
  int ntt_a2  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
  int ntt_tw  [12] = '{0, 1, 2, 3,  0, 2, 0, 2,  0, 0, 0, 0};
  int intt_a1 [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int intt_a2 [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int intt_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  logic       x_busy, x_done, x_sel, x_rd_en, x_wr_en;
  logic [2:0] x_ra1, x_ra2, x_wa1, x_wa2;
  logic [1:0] x_tw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int which);
    if (which == 0) begin
      x_busy = busy_a; x_done = done_a; x_sel = core_sel_a; x_rd_en = rd_en_a;
      x_wr_en = wr_en_a; x_ra1 = rd_addr_1_a; x_ra2 = rd_addr_2_a; x_tw = tw_addr_a;
      x_wa1 = wr_addr_1_a; x_wa2 = wr_addr_2_a;
    end else begin
      x_busy = busy_b; x_done = done_b; x_sel = core_sel_b; x_rd_en = rd_en_b;
      x_wr_en = wr_en_b; x_ra1 = rd_addr_1_b; x_ra2 = rd_addr_2_b; x_tw = tw_addr_b;
      x_wa1 = wr_addr_1_b; x_wa2 = wr_addr_2_b;
    end
  endtask

  // Cycle c (1 = cycle after the start-accept edge) -> schedule index, or -1 if no read.
  function automatic int rd_idx(input int lat, input int c);
    int q, p;
    if (c < 1) return -1;
    q = c - 1;
    p = 4 + lat;
    if ((q / p) < 3 && (q % p) < 4) return (q / p) * 4 + (q % p);
    return -1;
  endfunction

  function automatic int tab_a1(input int m, input int i);
    if (i < 0) return 0;
    return (m != 0) ? intt_a1[i] : ntt_a1[i];
  endfunction

  function automatic int tab_a2(input int m, input int i);
    if (i < 0) return 0;
    return (m != 0) ? intt_a2[i] : ntt_a2[i];
  endfunction

  function automatic int tab_tw(input int m, input int i);
    if (i < 0) return 0;
    return (m != 0) ? intt_tw[i] : ntt_tw[i];
  endfunction

  task automatic set_start(input int which, input logic s, input logic m);
    if (which == 0) begin start_a = s; mode_a = m; end
    else            begin start_b = s; mode_b = m; end
  endtask

  task automatic run_check(input int which, input int m, input int lat, input bit hold,
                           input string tag);
    int total, ri, wi;
    logic cur_mode;
    total    = 3 * (4 + lat) + 1;
    cur_mode = m[0];
    @(negedge clk);
    set_start(which, 1'b1, cur_mode);
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (hold) begin
        cur_mode = ~cur_mode;
        set_start(which, 1'b1, cur_mode);
      end else begin
        set_start(which, 1'b0, 1'b0);
      end
      sample(which);
      ri = rd_idx(lat, c);
      wi = rd_idx(lat, c - lat);
      chk($sformatf("%s_rd_en_c%0d", tag, c), 32'(x_rd_en), (ri >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_rd_addr_1_c%0d", tag, c), 32'(x_ra1), tab_a1(m, ri));
      chk($sformatf("%s_rd_addr_2_c%0d", tag, c), 32'(x_ra2), tab_a2(m, ri));
      chk($sformatf("%s_tw_addr_c%0d", tag, c), 32'(x_tw), tab_tw(m, ri));
      chk($sformatf("%s_wr_en_c%0d", tag, c), 32'(x_wr_en), (wi >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_wr_addr_1_c%0d", tag, c), 32'(x_wa1), tab_a1(m, wi));
      chk($sformatf("%s_wr_addr_2_c%0d", tag, c), 32'(x_wa2), tab_a2(m, wi));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(x_busy), (c < total) ? 32'd1 : 32'd0);
      chk($sformatf("%s_done_c%0d", tag, c), 32'(x_done), (c == total) ? 32'd1 : 32'd0);
      chk($sformatf("%s_core_sel_c%0d", tag, c), 32'(x_sel), 32'(m));
    end
    set_start(which, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      sample(which);
      chk($sformatf("%s_post_busy_%0d", tag, c), 32'(x_busy), 32'd0);
      chk($sformatf("%s_post_done_%0d", tag, c), 32'(x_done), 32'd0);
      chk($sformatf("%s_post_rd_en_%0d", tag, c), 32'(x_rd_en), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; mode_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w);
      chk($sformatf("reset_busy_%0d", w), 32'(x_busy), 32'd0);
      chk($sformatf("reset_done_%0d", w), 32'(x_done), 32'd0);
      chk($sformatf("reset_core_sel_%0d", w), 32'(x_sel), 32'd0);
      chk($sformatf("reset_rd_%0d", w), {26'd0, x_rd_en, x_ra1, x_ra2[1:0]}, 32'd0);
      chk($sformatf("reset_rd_hi_%0d", w), {29'd0, x_ra2[2], x_tw}, 32'd0);
      chk($sformatf("reset_wr_%0d", w), {25'd0, x_wr_en, x_wa1, x_wa2}, 32'd0);
    end
    rst = 1'b0;

    run_check(0, 0, 1, 1'b0, "ntt");
    run_check(0, 1, 1, 1'b0, "intt");
    run_check(0, 1, 1, 1'b1, "hold");

    // Reset in the middle of stage 1, then a clean rerun.
    @(negedge clk);
    start_a = 1'b1; mode_a = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("midrun_rd_en", 32'(rd_en_a), 32'd1);
    chk("midrun_wr_en", 32'(wr_en_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_wr_en", 32'(wr_en_a), 32'd0);
    chk("rst_rd_en", 32'(rd_en_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    run_check(0, 0, 1, 1'b0, "rerun");

    run_check(1, 0, 3, 1'b0, "lat3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
